ser_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one shift_serializer instance between NCH parallel requesters.
- Each requester offers FROM-bit words with a valid/ready handshake. The scheduler captures one word, issues it to the serializer with a one-cycle load pulse, and tracks the serializer's active window.
- It re-arbitrates only after the serializer has returned to idle. It also reports which channel owns the current serial stream.
- Sits between the per-channel word producers and the serializer's data_i/valid_i/valid_o pins.

---
 rtl/ser_rr_scheduler.sv | 124 ++++++++++++
 tb/tb_ser_rr_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_rr_scheduler.sv
// Round-robin scheduler sharing one shift serializer between NCH word producers.
// Captures one word per grant, pulses the serializer load, and waits for its active window to close.
module ser_rr_scheduler #(
  parameter int unsigned NCH           = 4,
  parameter int unsigned LOG2NCH       = 2,
  parameter int unsigned FROM          = 8,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NCH-1:0]        en_i,
  input  logic [NCH*FROM-1:0]   req_data_i,
  input  logic [NCH-1:0]        req_valid_i,
  output logic [NCH-1:0]        req_ready_o,
  output logic [FROM-1:0]       ser_data_o,
  output logic                  ser_valid_o,
  input  logic                  ser_active_i,
  output logic [LOG2NCH-1:0]    grant_id_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {ARB, LOAD, WAIT_START, WAIT_END} state_e;

  state_e              state_q, state_d;
  logic [LOG2NCH-1:0]  ptr_q, ptr_d;
  logic [LOG2NCH-1:0]  grant_q, grant_d;
  logic [FROM-1:0]     hold_q, hold_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ser_valid_q, ser_valid_d;
  logic                err_q, err_d;

  logic [NCH-1:0]      eligible;
  logic [LOG2NCH-1:0]  win;
  logic [LOG2NCH-1:0]  cand;
  logic                found;

  // Rotating search: candidates visited ptr+1, ptr+2, ... wrapping, so the last winner goes last.
  always_comb begin
    eligible = req_valid_i & en_i;
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = LOG2NCH'((32'(ptr_q) + k) % NCH);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    ser_valid_d = 1'b0;
    req_ready_o = '0;
    unique case (state_q)
      ARB: begin
        if (found) begin
          req_ready_o[win] = 1'b1;
          hold_d           = req_data_i[32'(win)*FROM +: FROM];
          grant_d          = win;
          ptr_d            = win;
          ser_valid_d      = 1'b1;
          state_d          = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = CW'(START_TIMEOUT);
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (ser_active_i) begin
          state_d = WAIT_END;
        end else begin
          cnt_d = cnt_q - CW'(1);
          // Serializer never started: drop the word and flag it permanently.
          if (cnt_q == CW'(1)) begin
            err_d   = 1'b1;
            state_d = ARB;
          end
        end
      end
      WAIT_END: begin
        if (!ser_active_i) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB;
      ptr_q       <= LOG2NCH'(NCH - 1);
      grant_q     <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      ser_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      ser_valid_q <= ser_valid_d;
      err_q       <= err_d;
    end
  end

  assign ser_data_o  = hold_q;
  assign ser_valid_o = ser_valid_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = (state_q != ARB);
  assign err_o       = err_q;

endmodule

// File: tb/tb_ser_rr_scheduler.sv
// Bench for ser_rr_scheduler: transaction-level reference model feeds a scoreboard,
// a separate monitor compares DUT outputs; a small serializer model drives ser_active_i.
module tb_ser_rr_scheduler;

  localparam int NCH           = 4;
  localparam int LOG2NCH       = 2;
  localparam int FROM          = 8;
  localparam int START_TIMEOUT = 4;
  localparam int ACT_LEN       = 5;
  localparam int NEVER         = 32'h7fff_ffff;

  logic                 clk;
  logic                 reset_n;
  logic [NCH-1:0]       en_i;
  logic [NCH*FROM-1:0]  req_data_i;
  logic [NCH-1:0]       req_valid_i;
  logic [NCH-1:0]       req_ready_o;
  logic [FROM-1:0]      ser_data_o;
  logic                 ser_valid_o;
  logic                 ser_active_i;
  logic [LOG2NCH-1:0]   grant_id_o;
  logic                 busy_o;
  logic                 err_o;

  ser_rr_scheduler #(
    .NCH(NCH), .LOG2NCH(LOG2NCH), .FROM(FROM), .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en_i(en_i), .req_data_i(req_data_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .ser_data_o(ser_data_o),
    .ser_valid_o(ser_valid_o), .ser_active_i(ser_active_i), .grant_id_o(grant_id_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    int             cyc;
    int             g;
    logic [FROM-1:0] data;
  } item_t;

  item_t acc_q[$];
  item_t ld_q[$];
  int    glog[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ld_cnt = 0;
  int   free_at = 0;
  int   busy_from = NEVER;
  int   err_at = NEVER;
  logic dead = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Serializer stand-in: a load pulse starts ACT_LEN active cycles unless dead.
  initial begin : serializer
    int   act_cnt;
    logic sv;
    act_cnt      = 0;
    ser_active_i = 1'b0;
    forever begin
      @(negedge clk);
      sv = ser_valid_o;
      @(posedge clk);
      #1;
      if (!reset_n) act_cnt = 0;
      else begin
        if (act_cnt > 0) act_cnt--;
        if (sv && !dead) act_cnt = ACT_LEN;
      end
      ser_active_i = (act_cnt > 0);
    end
  end

  // Reference model: scheduler is free from free_at; a grant rotates from the last winner.
  initial begin : model
    int             ptr;
    int             g;
    int             c;
    logic [NCH-1:0] elig;
    item_t          it;
    ptr = NCH - 1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        ptr       = NCH - 1;
        free_at   = 0;
        busy_from = NEVER;
        err_at    = NEVER;
        acc_q.delete();
        ld_q.delete();
      end else if (cyc >= free_at) begin
        elig = req_valid_i & en_i;
        g = -1;
        for (int k = 1; k <= NCH; k++) begin
          c = (ptr + k) % NCH;
          if (g < 0 && elig[c[LOG2NCH-1:0]]) g = c;
        end
        if (g >= 0) begin
          it.cyc  = cyc;
          it.g    = g;
          it.data = req_data_i[g*FROM +: FROM];
          acc_q.push_back(it);
          it.cyc  = cyc + 1;
          ld_q.push_back(it);
          ptr       = g;
          busy_from = cyc + 1;
          if (dead) begin
            free_at = cyc + 2 + START_TIMEOUT;
            if (err_at == NEVER) err_at = free_at;
          end else begin
            free_at = cyc + 3 + ACT_LEN;
          end
        end
      end
    end
  end

  initial begin : monitor
    item_t it;
    int    exp_busy;
    int    exp_err;
    forever begin
      @(negedge clk);
      #2;
      if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
        it = acc_q.pop_front();
        chk("accept_onehot", int'(req_ready_o), 1 << it.g);
      end else begin
        chk("no_accept", int'(req_ready_o), 0);
      end
      for (int c = 0; c < NCH; c++)
        if (req_ready_o[c[LOG2NCH-1:0]]) glog.push_back(c);
      if (ld_q.size() > 0 && ld_q[0].cyc == cyc) begin
        it = ld_q.pop_front();
        chk("load_pulse", int'(ser_valid_o), 1);
        chk("load_data", int'(ser_data_o), int'(it.data));
        chk("load_grant", int'(grant_id_o), it.g);
      end else begin
        chk("no_load", int'(ser_valid_o), 0);
      end
      if (ser_valid_o) ld_cnt++;
      exp_busy = (reset_n && cyc >= busy_from && cyc < free_at) ? 1 : 0;
      exp_err  = (reset_n && cyc >= err_at) ? 1 : 0;
      chk("busy", int'(busy_o), exp_busy);
      chk("err", int'(err_o), exp_err);
      chk("load_while_active", int'(ser_valid_o & ser_active_i), 0);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, int'(req_ready_o), 0);
    chk({tag, "_ser_valid"}, int'(ser_valid_o), 0);
    chk({tag, "_ser_data"}, int'(ser_data_o), 0);
    chk({tag, "_grant"}, int'(grant_id_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_err"}, int'(err_o), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    check_all_zero("reset");
    reset_n = 1'b1;
  endtask

  initial begin : stim
    int n;
    int ld0;
    reset_n     = 1'b0;
    en_i        = '0;
    req_valid_i = '0;
    req_data_i  = '0;
    step(3);
    check_all_zero("por");
    reset_n = 1'b1;
    step(2);

    // Single channel 1 with 0xA5, held valid to exercise back-to-back re-grant spacing.
    en_i        = 4'hF;
    req_data_i  = 32'h00_00_A5_00;
    glog.delete();
    req_valid_i = 4'b0010;
    step(26);
    req_valid_i = '0;
    step(12);
    chk("ch1_grants", glog.size(), 4);
    n = 0;
    foreach (glog[i]) if (glog[i] != 1) n++;
    chk("ch1_only", n, 0);

    // All channels valid after reset: rotation starts at channel 0.
    do_reset();
    glog.delete();
    req_data_i  = 32'h44_33_22_11;
    req_valid_i = 4'hF;
    step(55);
    req_valid_i = '0;
    step(12);
    chk("rr_count", (glog.size() >= 6) ? 1 : 0, 1);
    for (int i = 0; i < 6; i++)
      chk("rr_order", (glog.size() > i) ? glog[i] : -1, i % NCH);

    // Channel 2 masked by en_i.
    glog.delete();
    en_i        = 4'b1011;
    req_data_i  = 32'h5A_3C_C3_A5;
    req_valid_i = 4'b0101;
    step(40);
    req_valid_i = '0;
    en_i        = 4'hF;
    step(12);
    chk("mask_grants", (glog.size() >= 3) ? 1 : 0, 1);
    n = 0;
    foreach (glog[i]) if (glog[i] != 0) n++;
    chk("mask_no_ch2", n, 0);

    // Channel 2 valid for one cycle while busy is never taken.
    glog.delete();
    ld0 = ld_cnt;
    req_valid_i = 4'b0001;
    step(1);
    req_valid_i = 4'b0100;
    step(1);
    req_valid_i = '0;
    step(25);
    chk("drop_grants", glog.size(), 1);
    chk("drop_winner", (glog.size() > 0) ? glog[0] : -1, 0);
    chk("drop_loads", ld_cnt - ld0, 1);

    // Serializer never starts: timeout, sticky error.
    dead = 1'b1;
    req_data_i  = 32'h0000_7E00;
    req_valid_i = 4'b0010;
    step(1);
    req_valid_i = '0;
    step(12);
    chk("timeout_err", int'(err_o), 1);
    dead = 1'b0;
    req_valid_i = 4'b0001;
    step(1);
    req_valid_i = '0;
    step(15);
    chk("err_sticky", int'(err_o), 1);

    // Reset while channel 3 is in WAIT_END.
    req_data_i  = 32'hC7_00_00_00;
    req_valid_i = 4'b1000;
    n = 0;
    while (!ser_active_i && n < 30) begin
      step(1);
      n++;
    end
    chk("wait_active", int'(ser_active_i), 1);
    req_valid_i = '0;
    step(2);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    step(2);
    glog.delete();
    reset_n     = 1'b1;
    req_data_i  = 32'h13_57_9B_DF;
    req_valid_i = 4'hF;
    step(3);
    req_valid_i = '0;
    chk("post_reset_first", (glog.size() > 0) ? glog[0] : -1, 0);
    step(12);

    // All channels disabled: must stay idle.
    en_i = '0;
    for (int i = 0; i < 30; i++) begin
      req_valid_i = NCH'($urandom);
      req_data_i  = $urandom;
      step(1);
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid_i = NCH'($urandom);
      en_i        = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : 4'hF;
      req_data_i  = $urandom;
      step(1);
    end
    req_valid_i = '0;
    step(20);
    chk("queue_drain", acc_q.size() + ld_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
